// File: rtl/wb_stage_pkg.sv
// Shared definitions for the rvseed writeback stage: datapath widths,
// load funct3 encodings and the load-type enumeration used by the
// load extension logic.
`ifndef WB_STAGE_DEFINES_SVH
`define WB_STAGE_DEFINES_SVH
`define CPU_WIDTH      32
`define REG_ADDR_WIDTH 5
`define FUNCT3_LB      3'b000
`define FUNCT3_LH      3'b001
`define FUNCT3_LW      3'b010
`define FUNCT3_LBU     3'b100
`define FUNCT3_LHU     3'b101
`endif

package wb_stage_pkg;

  localparam int unsigned CPU_WIDTH      = `CPU_WIDTH;
  localparam int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH;
  localparam int unsigned LQ_DEPTH_DEF   = 2;

  // Load types as encoded in the funct3 field of a load instruction.
  typedef enum logic [2:0] {
    LOAD_LB  = `FUNCT3_LB,
    LOAD_LH  = `FUNCT3_LH,
    LOAD_LW  = `FUNCT3_LW,
    LOAD_LBU = `FUNCT3_LBU,
    LOAD_LHU = `FUNCT3_LHU
  } load_type_e;

endpackage

// File: rtl/wb_load_ext.sv
// Load data extension for the writeback stage. Selects the addressed
// byte or halfword out of the raw memory word and sign- or zero-extends
// it according to the load funct3. Unknown funct3 values pass the word.
module wb_load_ext
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_WIDTH
) (
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_boff,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_data
);

  load_type_e  w_type;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_type = load_type_e'(i_funct3);

  // Halfword lane: only boff[1] matters, boff[0] is ignored.
  assign w_half = i_boff[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Byte lane selection by byte offset within the word.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_boff)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // Extension according to load type.
  always_comb begin
    o_data = i_rdata;
    case (w_type)
      LOAD_LB:  o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LOAD_LBU: o_data = {{(DATA_W-8){1'b0}}, w_byte};
      LOAD_LH:  o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      LOAD_LHU: o_data = {{(DATA_W-16){1'b0}}, w_half};
      LOAD_LW:  o_data = i_rdata;
      default:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the rvseed core. Owns the register-file write port
// and merges execute results with buffered LSU load responses. Loads
// waiting in the queue always win over the execute path; writes to x0
// are dropped; the write port is registered.
// Optional macro HISOC_WB_FWD_EN adds same-cycle forwarding outputs so
// decode can bypass a register read that collides with the write.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_WIDTH,
  parameter int unsigned ADDR_W   = REG_ADDR_WIDTH,
  parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              lsu_rvalid,
  output logic              lsu_rready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [2:0]        lsu_funct3,
  input  logic [1:0]        lsu_boff,
  input  logic [DATA_W-1:0] lsu_rdata,
`ifdef HISOC_WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd1_raddr,
  input  logic [ADDR_W-1:0] fwd2_raddr,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              reg_wen,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata
);

  localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LQ_FULL = CNT_W'(LQ_DEPTH);

  logic [ADDR_W-1:0] r_lq_rd     [LQ_DEPTH];
  logic [2:0]        r_lq_funct3 [LQ_DEPTH];
  logic [1:0]        r_lq_boff   [LQ_DEPTH];
  logic [DATA_W-1:0] r_lq_rdata  [LQ_DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_load_data;
  logic              w_cand_valid;
  logic [ADDR_W-1:0] w_cand_rd;
  logic [DATA_W-1:0] w_cand_data;

  // Queue state alone decides both handshakes, so neither ready depends
  // on the same-cycle valids.
  assign lsu_rready = (r_count != LQ_FULL);
  assign ex_ready   = (r_count == '0);
  assign w_push     = lsu_rvalid && lsu_rready;
  assign w_pop      = (r_count != '0);

  // Load queue payload storage; written at the tail on every push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lq_rd[r_wr_ptr]     <= lsu_rd;
      r_lq_funct3[r_wr_ptr] <= lsu_funct3;
      r_lq_boff[r_wr_ptr]   <= lsu_boff;
      r_lq_rdata[r_wr_ptr]  <= lsu_rdata;
    end
  end

  // Load queue pointers and occupancy; reset drops any queued loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  wb_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .i_funct3 (r_lq_funct3[r_rd_ptr]),
    .i_boff   (r_lq_boff[r_rd_ptr]),
    .i_rdata  (r_lq_rdata[r_rd_ptr]),
    .o_data   (w_load_data)
  );

  // Pick the write candidate: queue head first, execute only when empty.
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand_rd    = '0;
    w_cand_data  = '0;
    if (w_pop) begin
      w_cand_valid = 1'b1;
      w_cand_rd    = r_lq_rd[r_rd_ptr];
      w_cand_data  = w_load_data;
    end else if (ex_valid) begin
      w_cand_valid = 1'b1;
      w_cand_rd    = ex_rd;
      w_cand_data  = ex_data;
    end
  end

  // Register the write port; address/data hold when nothing is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_cand_valid && (w_cand_rd != '0);
      if (w_cand_valid) begin
        r_waddr <= w_cand_rd;
        r_wdata <= w_cand_data;
      end
    end
  end

  assign reg_wen   = r_wen;
  assign reg_waddr = r_waddr;
  assign reg_wdata = r_wdata;

`ifdef HISOC_WB_FWD_EN
  assign fwd1_hit = r_wen && (r_waddr == fwd1_raddr) && (fwd1_raddr != '0);
  assign fwd2_hit = r_wen && (r_waddr == fwd2_raddr) && (fwd2_raddr != '0);
  assign fwd_data = r_wdata;
`else
  // Without forwarding, decode reads only the register file.
`endif

endmodule
